// File: rtl/multicycle_core.sv
// Multi-cycle AR/T core: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack instruction and data
// ports, a 16-entry register file and PC. Assumes DATA_W >= 19 and ADDR_W >= 19.
module multicycle_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PC_INC = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned ShW = $clog2(DATA_W);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [4:0] OpAr   = 5'b00000;
  localparam logic [4:0] OpT    = 5'b00001;
  localparam logic [4:0] OpLd   = 5'b00010;
  localparam logic [4:0] OpSt   = 5'b00011;
  localparam logic [4:0] OpBz   = 5'b00100;
  localparam logic [4:0] OpHalt = 5'b11111;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              illegal_q, illegal_d;
  logic              booted_q;
  logic [DATA_W-1:0] regs_q [16];

  logic              rf_we;
  logic [3:0]        rf_waddr;

  logic [4:0]        op;
  logic [3:0]        fn, ra, rb, rc;
  logic [DATA_W-1:0] sext19_d, sext15_d, alu_res;
  logic [ADDR_W-1:0] sext19_a, pc_next;
  logic [ShW-1:0]    shamt;
  logic              op_legal;

  assign op       = ir_q[31:27];
  assign fn       = ir_q[26:23];
  assign ra       = ir_q[22:19];
  assign rb       = ir_q[18:15];
  assign rc       = ir_q[14:11];
  assign sext19_d = DATA_W'($signed(ir_q[18:0]));
  assign sext15_d = DATA_W'($signed(ir_q[14:0]));
  assign sext19_a = ADDR_W'($signed(ir_q[18:0]));
  assign pc_next  = pc_q + ADDR_W'(PC_INC);
  assign shamt    = opb_q[ShW-1:0];
  assign rf_waddr = (op == OpAr) ? rc : ra;

  assign op_legal = ((op == OpAr) && !fn[3]) || (op == OpT) || (op == OpLd) ||
                    (op == OpSt) || (op == OpBz) || (op == OpHalt);

  always_comb begin
    alu_res = '0;
    case (fn[2:0])
      3'd0:    alu_res = opa_q + opb_q;
      3'd1:    alu_res = opa_q - opb_q;
      3'd2:    alu_res = opa_q & opb_q;
      3'd3:    alu_res = opa_q | opb_q;
      3'd4:    alu_res = opa_q ^ opb_q;
      3'd5:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
      3'd6:    alu_res = opa_q << shamt;
      default: alu_res = opa_q >> shamt;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    case (state_q)
      StFetch: begin
        if (imem_req && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        opa_d = regs_q[ra];
        opb_d = regs_q[rb];
        if (op_legal) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExec: begin
        case (op)
          OpAr: begin
            res_d   = alu_res;
            state_d = StWb;
          end
          OpT: begin
            res_d   = sext19_d;
            state_d = StWb;
          end
          OpLd, OpSt: begin
            res_d   = opb_q + sext15_d;
            state_d = StMem;
          end
          OpBz: begin
            pc_d    = (opa_q == '0) ? pc_q + sext19_a : pc_next;
            state_d = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        if (dmem_ack) begin
          if (op == OpSt) begin
            pc_d    = pc_next;
            state_d = StFetch;
          end else begin
            res_d   = dmem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        pc_d    = pc_next;
        state_d = StFetch;
      end
      default: state_d = StHalt;
    endcase
  end

  // pc loads start_pc asynchronously so the first fetch address is valid as reset releases.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StFetch;
      pc_q      <= start_pc;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
      booted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
      booted_q  <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= res_q;
    end
  end

  // booted_q keeps the fetch request low while reset is held and for the release cycle.
  assign imem_req   = booted_q && (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == StMem);
  assign dmem_we    = dmem_req && (op == OpSt);
  assign dmem_addr  = dmem_req ? ADDR_W'(res_q) : '0;
  assign dmem_wdata = dmem_we ? opa_q : '0;
  assign retire     = (state_q == StWb) ||
                      ((state_q == StExec) && (op == OpBz)) ||
                      ((state_q == StMem) && dmem_ack && (op == OpSt));
  assign halted     = (state_q == StHalt);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: ALU vector table, directed multi-cycle sequences and random
// programs checked against an instruction-level reference interpreter.
module tb_multicycle_core;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] start_pc = '0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        retire, halted, illegal;

  multicycle_core dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start_pc   (start_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .retire     (retire),
    .halted     (halted),
    .illegal    (illegal)
  );

  initial forever #5 CLK = ~CLK;

  localparam logic [31:0] Halt = 32'hF800_0000;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] mdm  [256];
  int          imem_wait = 0, dmem_wait = 0;  // -1 selects a random 0..2 wait per access
  bit          spurious = 1'b0;
  logic [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
  longint      cyc = 0;
  longint      ret_cyc[$];
  int          ret_cnt = 0;
  int          exp_retire;
  logic [31:0] exp_halt_pc;
  logic        exp_illegal;
  int          n_pass = 0, n_total = 0;

  typedef struct {
    string       name;
    logic [3:0]  fn;
    logic [18:0] va;
    logic [18:0] vb;
    logic [31:0] exp;
  } alu_vec_t;
  alu_vec_t vecs [13];

  function automatic logic [31:0] enc_ar(logic [3:0] f, logic [3:0] a, logic [3:0] b,
                                         logic [3:0] c);
    return {5'd0, f, a, b, c, 11'd0};
  endfunction
  function automatic logic [31:0] enc_t(logic [3:0] a, logic [18:0] imm);
    return {5'd1, 4'd0, a, imm};
  endfunction
  function automatic logic [31:0] enc_ld(logic [3:0] a, logic [3:0] b, logic [14:0] imm);
    return {5'd2, 4'd0, a, b, imm};
  endfunction
  function automatic logic [31:0] enc_st(logic [3:0] a, logic [3:0] b, logic [14:0] imm);
    return {5'd3, 4'd0, a, b, imm};
  endfunction
  function automatic logic [31:0] enc_bz(logic [3:0] a, logic [18:0] imm);
    return {5'd4, 4'd0, a, imm};
  endfunction

  initial forever @(posedge CLK) cyc++;

  // Instruction memory responder
  initial begin
    int icnt, itgt;
    bit ibusy;
    ibusy = 1'b0; icnt = 0; itgt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET || !imem_req) begin
        ibusy      = 1'b0;
        imem_ack   = RESET && spurious && ($urandom_range(1, 0) == 1);
        imem_rdata = $urandom;
      end else begin
        if (!ibusy) begin
          ibusy = 1'b1;
          icnt  = 0;
          itgt  = (imem_wait < 0) ? int'($urandom_range(2, 0)) : imem_wait;
        end
        if (icnt >= itgt) begin
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr[7:0]];
        end else begin
          imem_ack = 1'b0;
          icnt++;
        end
      end
    end
  end

  // Data memory responder; records every completed store
  initial begin
    int dcnt, dtgt;
    bit dbusy;
    dbusy = 1'b0; dcnt = 0; dtgt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        obs_addr.delete();
        obs_data.delete();
      end
      if (!RESET || !dmem_req) begin
        dbusy      = 1'b0;
        dmem_ack   = RESET && spurious && ($urandom_range(1, 0) == 1);
        dmem_rdata = $urandom;
      end else begin
        if (!dbusy) begin
          dbusy = 1'b1;
          dcnt  = 0;
          dtgt  = (dmem_wait < 0) ? int'($urandom_range(2, 0)) : dmem_wait;
        end
        if (dcnt >= dtgt) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            dmem[dmem_addr[7:0]] = dmem_wdata;
            obs_addr.push_back(dmem_addr);
            obs_data.push_back(dmem_wdata);
          end else begin
            dmem_rdata = dmem[dmem_addr[7:0]];
          end
        end else begin
          dmem_ack = 1'b0;
          dcnt++;
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    #1;
    if (!RESET) begin
      ret_cnt = 0;
      ret_cyc.delete();
    end else if (retire) begin
      ret_cnt++;
      ret_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_alu(logic [3:0] f, logic [31:0] x, logic [31:0] y);
    case (f)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      4'd4:    return x ^ y;
      4'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:    return x << y[4:0];
      default: return x >> y[4:0];
    endcase
  endfunction

  // Instruction-set interpreter; must be called before the DUT runs the same program.
  task automatic run_model(input logic [31:0] spc);
    logic [31:0] r [16];
    logic [31:0] pc, ins, ea, s19, s15;
    logic [4:0]  op;
    logic [3:0]  f, a, b, c;
    bit          done;
    for (int i = 0; i < 256; i++) mdm[i] = dmem[i];
    for (int i = 0; i < 16; i++) r[i] = '0;
    exp_addr.delete(); exp_data.delete();
    exp_retire = 0; exp_illegal = 1'b0; exp_halt_pc = 'x;
    pc = spc; done = 1'b0;
    for (int s = 0; s < 400 && !done; s++) begin
      ins = imem[pc[7:0]];
      op = ins[31:27]; f = ins[26:23]; a = ins[22:19]; b = ins[18:15]; c = ins[14:11];
      s19 = 32'($signed(ins[18:0]));
      s15 = 32'($signed(ins[14:0]));
      ea  = r[b] + s15;
      case (op)
        5'd0: if (f > 4'd7) begin
                done = 1'b1; exp_illegal = 1'b1;
              end else begin
                r[c] = ref_alu(f, r[a], r[b]); pc++; exp_retire++;
              end
        5'd1: begin r[a] = s19; pc++; exp_retire++; end
        5'd2: begin r[a] = mdm[ea[7:0]]; pc++; exp_retire++; end
        5'd3: begin
                exp_addr.push_back(ea); exp_data.push_back(r[a]);
                mdm[ea[7:0]] = r[a]; pc++; exp_retire++;
              end
        5'd4: begin pc = (r[a] == '0) ? pc + s19 : pc + 1; exp_retire++; end
        5'd31: done = 1'b1;
        default: begin done = 1'b1; exp_illegal = 1'b1; end
      endcase
    end
    if (done) exp_halt_pc = pc;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = Halt;
  endtask

  task automatic do_reset(input logic [31:0] spc);
    @(negedge CLK);
    RESET = 1'b0;
    start_pc = spc;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int i;
    i = 0;
    while (!halted && i < 3000) begin
      @(negedge CLK);
      i++;
    end
    if (!halted) chk({name, "_timeout"}, 32'd0, 32'd1);
    @(negedge CLK);
    #2;
  endtask

  task automatic compare_model(input string name);
    int n;
    chk({name, "_retires"}, 32'(ret_cnt), 32'(exp_retire));
    chk({name, "_stores"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_st%0d_addr", name, i), obs_addr[i], exp_addr[i]);
      chk($sformatf("%s_st%0d_data", name, i), obs_data[i], exp_data[i]);
    end
    chk({name, "_halt_pc"}, imem_addr, exp_halt_pc);
    chk({name, "_halted"}, 32'(halted), 32'd1);
    chk({name, "_illegal"}, 32'(illegal), 32'(exp_illegal));
    chk({name, "_imem_req_idle"}, 32'(imem_req), 32'd0);
  endtask

  task automatic chk_lat(input string name, input int idx, input int exp);
    if (ret_cyc.size() > idx) chk(name, 32'(ret_cyc[idx] - ret_cyc[idx-1]), 32'(exp));
    else chk({name, "_missing"}, 32'(ret_cyc.size()), 32'(idx + 1));
  endtask

  initial begin
    logic [31:0] spc;
    vecs[0]  = '{"add",      4'd0, 19'd5,         19'(-3),  32'd2};
    vecs[1]  = '{"sub",      4'd1, 19'd5,         19'(-3),  32'd8};
    vecs[2]  = '{"and",      4'd2, 19'h0F0F,      19'h00FF, 32'h0000_000F};
    vecs[3]  = '{"or",       4'd3, 19'h0F00,      19'h00FF, 32'h0000_0FFF};
    vecs[4]  = '{"xor",      4'd4, 19'h0FF0,      19'h00FF, 32'h0000_0F0F};
    vecs[5]  = '{"slt_t",    4'd5, 19'(-3),       19'd5,    32'd1};
    vecs[6]  = '{"slt_f",    4'd5, 19'd5,         19'(-3),  32'd0};
    vecs[7]  = '{"sll31",    4'd6, 19'd1,         19'd31,   32'h8000_0000};
    vecs[8]  = '{"sll_mod",  4'd6, 19'd3,         19'd33,   32'd6};
    vecs[9]  = '{"srl28",    4'd7, 19'(-1),       19'd28,   32'h0000_000F};
    vecs[10] = '{"srl4",     4'd7, 19'(-16),      19'd4,    32'h0FFF_FFFF};
    vecs[11] = '{"sub_wrap", 4'd1, 19'd0,         19'd1,    32'hFFFF_FFFF};
    vecs[12] = '{"add_wrap", 4'd0, 19'(-1),       19'd1,    32'd0};
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Reset values and first fetch address; program stores every register.
    clear_imem();
    for (int i = 0; i < 16; i++) imem[8'h10 + i] = enc_st(4'(i), 4'(i), 15'd0);
    run_model(32'h10);
    @(negedge CLK);
    RESET = 1'b0;
    start_pc = 32'h10;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("boot_imem_addr", imem_addr, 32'h10);
    chk("boot_imem_req", 32'(imem_req), 32'd1);
    wait_halt("regs_zero");
    compare_model("regs_zero");

    // ALU vector table
    foreach (vecs[i]) begin
      clear_imem();
      imem[0] = enc_t(4'd1, vecs[i].va);
      imem[1] = enc_t(4'd2, vecs[i].vb);
      imem[2] = enc_ar(vecs[i].fn, 4'd1, 4'd2, 4'd3);
      imem[3] = enc_st(4'd3, 4'd0, 15'h40);
      do_reset(32'd0);
      wait_halt({"alu_", vecs[i].name});
      chk({"alu_", vecs[i].name}, (obs_data.size() > 0) ? obs_data[0] : 32'hDEAD_BEEF,
          vecs[i].exp);
    end

    // T/T/ADD/SLT then HALT: four retires, 4 cycles apart.
    clear_imem();
    imem[0] = enc_t(4'd1, 19'd5);
    imem[1] = enc_t(4'd2, 19'(-3));
    imem[2] = enc_ar(4'd0, 4'd1, 4'd2, 4'd3);
    imem[3] = enc_ar(4'd5, 4'd2, 4'd1, 4'd4);
    run_model(32'd0);
    do_reset(32'd0);
    wait_halt("seq2");
    compare_model("seq2");
    for (int i = 1; i < 4; i++) chk_lat($sformatf("seq2_lat%0d", i), i, 4);

    // Store then load with three stall cycles on every data access.
    clear_imem();
    imem[0] = enc_t(4'd1, 19'd5);
    imem[1] = enc_st(4'd1, 4'd0, 15'd7);
    imem[2] = enc_ld(4'd5, 4'd0, 15'd7);
    imem[3] = enc_st(4'd5, 4'd0, 15'd8);
    dmem_wait = 3;
    run_model(32'd0);
    do_reset(32'd0);
    wait_halt("ldst");
    compare_model("ldst");
    chk_lat("ldst_st_lat", 1, 7);
    chk_lat("ldst_ld_lat", 2, 8);
    chk_lat("ldst_st2_lat", 3, 7);
    dmem_wait = 0;

    // Branches: taken backward, not taken, and wrap below zero.
    clear_imem();
    imem[8'h20] = enc_bz(4'd0, 19'(-2));
    run_model(32'h20);
    do_reset(32'h20);
    wait_halt("bz_taken");
    compare_model("bz_taken");
    clear_imem();
    imem[8'h1F] = enc_t(4'd1, 19'd5);
    imem[8'h20] = enc_bz(4'd1, 19'(-2));
    run_model(32'h1F);
    do_reset(32'h1F);
    wait_halt("bz_not");
    compare_model("bz_not");
    chk_lat("bz_lat", 1, 3);
    clear_imem();
    imem[0] = enc_bz(4'd0, 19'(-1));
    run_model(32'd0);
    do_reset(32'd0);
    wait_halt("bz_wrap");
    compare_model("bz_wrap");

    // Illegal opcode and illegal ALU function.
    clear_imem();
    imem[5] = {5'b01010, 27'd0};
    run_model(32'd5);
    do_reset(32'd5);
    wait_halt("ill_op");
    compare_model("ill_op");
    clear_imem();
    imem[0] = enc_t(4'd1, 19'd5);
    imem[1] = enc_ar(4'd9, 4'd1, 4'd1, 4'd2);
    run_model(32'd0);
    do_reset(32'd0);
    wait_halt("ill_fn");
    compare_model("ill_fn");

    // Reset while a fetch is stalled.
    clear_imem();
    imem_wait = 100;
    do_reset(32'd0);
    repeat (3) @(negedge CLK);
    #1;
    chk("stall_req", 32'(imem_req), 32'd1);
    RESET = 1'b0;
    #1;
    chk("stall_rst_req", 32'(imem_req), 32'd0);
    start_pc = 32'h30;
    imem_wait = 0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("restart_addr", imem_addr, 32'h30);
    chk("restart_req", 32'(imem_req), 32'd1);
    wait_halt("restart");
    chk("restart_halt_pc", imem_addr, 32'h30);

    // Random programs with random stalls and spurious acks while idle.
    imem_wait = -1;
    dmem_wait = -1;
    spurious  = 1'b1;
    for (int p = 0; p < 20; p++) begin
      clear_imem();
      for (int i = 0; i < 256; i++) dmem[i] = $urandom;
      spc = 32'($urandom_range(255, 0));
      for (int i = 0; i < 12; i++) begin
        logic [31:0] ins;
        case ($urandom_range(4, 0))
          0: ins = enc_ar(4'($urandom_range(7, 0)), 4'($urandom), 4'($urandom), 4'($urandom));
          1: ins = enc_t(4'($urandom), 19'($urandom));
          2: ins = enc_ld(4'($urandom), 4'($urandom), 15'($urandom));
          3: ins = enc_st(4'($urandom), 4'($urandom), 15'($urandom));
          default: ins = enc_bz(4'($urandom), 19'($urandom_range(3, 1)));
        endcase
        imem[8'(spc + 32'(i))] = ins;
      end
      for (int i = 0; i < 16; i++) imem[8'(spc + 32'(12 + i))] = enc_st(4'(i), 4'(i), 15'd0);
      run_model(spc);
      do_reset(spc);
      wait_halt($sformatf("rnd%0d", p));
      compare_model($sformatf("rnd%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
